// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit:
// op encodings, default latencies and op-class helper.
package mult_div_unit_pkg;

   typedef enum logic [3:0] {
      MDU_NOP   = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6,
      MDU_MFHI  = 4'd7,
      MDU_MFLO  = 4'd8
   } mduop_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Long ops occupy the unit and raise busy.
   function automatic logic is_long_op(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO.
// Ports: clk, reset (sync, active-high), start, MDUOP[3:0],
//   SrcA/SrcB operands; busy, HI, LO, MDUOut (mfhi/mflo value).
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       MDUOP,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] MDUOut
);

   localparam int MAXC =
      (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);

   mduop_e op;
   assign op = mduop_e'(MDUOP);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] shi_q, shi_d;
   logic [WIDTH-1:0] slo_q, slo_d;

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic [WIDTH-1:0]   quo_s, rem_s;
   logic [WIDTH-1:0]   quo_u, rem_u;
   logic               div_zero;
   logic               div_ovf;

   always_comb begin
      prod_s = $signed({{WIDTH{SrcA[WIDTH-1]}}, SrcA}) *
               $signed({{WIDTH{SrcB[WIDTH-1]}}, SrcB});
      prod_u = {{WIDTH{1'b0}}, SrcA} *
               {{WIDTH{1'b0}}, SrcB};
   end

   // Most-negative / -1 overflows the signed quotient; pin it
   // explicitly rather than trust the simulator's wrap.
   always_comb begin
      div_zero = (SrcB == '0);
      div_ovf  = (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (&SrcB);
      quo_s    = '0;
      rem_s    = '0;
      quo_u    = '0;
      rem_u    = '0;
      if (!div_zero) begin
         quo_u = SrcA / SrcB;
         rem_u = SrcA % SrcB;
         if (div_ovf) begin
            quo_s = SrcA;
            rem_s = '0;
         end else begin
            quo_s = $unsigned($signed(SrcA) / $signed(SrcB));
            rem_s = $unsigned($signed(SrcA) % $signed(SrcB));
         end
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      shi_d  = shi_q;
      slo_d  = slo_q;
      if (busy_q) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            hi_d   = shi_q;
            lo_d   = slo_q;
         end
      end else if (start) begin
         if (is_long_op(MDUOP)) begin
            busy_d = 1'b1;
         end
         unique case (op)
            MDU_MULT: begin
               shi_d = prod_s[2*WIDTH-1:WIDTH];
               slo_d = prod_s[WIDTH-1:0];
               cnt_d = CW'(MULT_CYCLES);
            end
            MDU_MULTU: begin
               shi_d = prod_u[2*WIDTH-1:WIDTH];
               slo_d = prod_u[WIDTH-1:0];
               cnt_d = CW'(MULT_CYCLES);
            end
            // Divide by zero commits the current HI/LO back,
            // which cannot change while the unit is busy.
            MDU_DIV: begin
               shi_d = div_zero ? hi_q : rem_s;
               slo_d = div_zero ? lo_q : quo_s;
               cnt_d = CW'(DIV_CYCLES);
            end
            MDU_DIVU: begin
               shi_d = div_zero ? hi_q : rem_u;
               slo_d = div_zero ? lo_q : quo_u;
               cnt_d = CW'(DIV_CYCLES);
            end
            MDU_MTHI: hi_d = SrcA;
            MDU_MTLO: lo_d = SrcA;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         shi_q  <= '0;
         slo_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         shi_q  <= shi_d;
         slo_q  <= slo_d;
      end
   end

   always_comb begin
      unique case (op)
         MDU_MFHI: MDUOut = hi_q;
         MDU_MFLO: MDUOut = lo_q;
         default:  MDUOut = '0;
      endcase
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle model plus
// directed vectors with literal expectations.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  MDUOP;
   logic [31:0] SrcA, SrcB;
   logic        busy;
   logic [31:0] HI, LO, MDUOut;

   int errs   = 0;
   int checks = 0;

   mult_div_unit dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .MDUOP  (MDUOP),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .busy   (busy),
      .HI     (HI),
      .LO     (LO),
      .MDUOut (MDUOut)
   );

   always #5 clk = ~clk;

   // Behavioural model: a scheduled commit at a cycle number.
   longint      mcyc = 0;
   longint      pend_end = 0;
   logic        pend = 1'b0;
   logic        pwr = 1'b0;
   logic        mvalid = 1'b0;
   logic [31:0] mhi = 0, mlo = 0, phi = 0, plo = 0;

   task automatic model_issue();
      int              sa, sb;
      longint          ps, qa, qb, q, r;
      longint unsigned pu;
      sa = SrcA;
      sb = SrcB;
      case (MDUOP)
         4'd1: begin
            ps = longint'(sa) * longint'(sb);
            phi = ps[63:32]; plo = ps[31:0];
            pwr = 1; pend = 1; pend_end = mcyc + 5;
         end
         4'd2: begin
            pu = {32'b0, SrcA} * {32'b0, SrcB};
            phi = pu[63:32]; plo = pu[31:0];
            pwr = 1; pend = 1; pend_end = mcyc + 5;
         end
         4'd3: begin
            pwr = (SrcB != 0);
            if (pwr) begin
               qa = longint'(sa); qb = longint'(sb);
               q = qa / qb; r = qa % qb;
               phi = r[31:0]; plo = q[31:0];
            end
            pend = 1; pend_end = mcyc + 10;
         end
         4'd4: begin
            pwr = (SrcB != 0);
            if (pwr) begin
               phi = SrcA % SrcB; plo = SrcA / SrcB;
            end
            pend = 1; pend_end = mcyc + 10;
         end
         4'd5: mhi = SrcA;
         4'd6: mlo = SrcA;
         default: ;
      endcase
   endtask

   always @(posedge clk) begin
      if (reset) begin
         mhi = 0; mlo = 0; pend = 0; mvalid = 1;
      end else if (pend) begin
         if (mcyc == pend_end) begin
            if (pwr) begin
               mhi = phi; mlo = plo;
            end
            pend = 0;
         end
      end else if (start) begin
         model_issue();
      end
      mcyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      logic [31:0] eout;
      if (mvalid) begin
         eout = (MDUOP == 4'd7) ? mhi :
                (MDUOP == 4'd8) ? mlo : 32'h0;
         chk("model busy", {31'b0, busy}, {31'b0, pend});
         chk("model HI", HI, mhi);
         chk("model LO", LO, mlo);
         chk("model MDUOut", MDUOut, eout);
      end
   end

   logic        l_busy;
   logic [31:0] l_hi, l_lo, l_out;

   task automatic tick(input logic r, input logic s,
                       input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
      reset = r; start = s; MDUOP = op; SrcA = a; SrcB = b;
      @(negedge clk);
      l_busy = busy; l_hi = HI; l_lo = LO; l_out = MDUOut;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 4'd0, 0, 0);
   endtask

   task automatic chk_busy(input string nm, input logic e);
      chk(nm, {31'b0, l_busy}, {31'b0, e});
   endtask

   initial begin
      tick(1, 0, 4'd0, 0, 0);
      tick(1, 0, 4'd0, 0, 0);
      tick(0, 0, 4'd0, 0, 0);
      chk_busy("reset busy", 0);
      chk("reset HI", l_hi, 32'h0);
      chk("reset LO", l_lo, 32'h0);
      chk("reset out", l_out, 32'h0);

      // MULT -2*3, then MULTU back-to-back at T+6
      tick(0, 1, 4'd1, 32'hFFFFFFFE, 32'd3);
      for (int i = 0; i < 5; i++) begin
         idle(1);
         chk_busy("mult busy", 1);
      end
      tick(0, 1, 4'd2, 32'hFFFFFFFE, 32'd3);
      chk_busy("mult done", 0);
      chk("mult HI", l_hi, 32'hFFFFFFFF);
      chk("mult LO", l_lo, 32'hFFFFFFFA);
      for (int i = 0; i < 5; i++) begin
         idle(1);
         chk_busy("multu busy", 1);
      end
      idle(1);
      chk("multu HI", l_hi, 32'h2);
      chk("multu LO", l_lo, 32'hFFFFFFFA);

      // DIV -7/2
      tick(0, 1, 4'd3, 32'hFFFFFFF9, 32'd2);
      for (int i = 0; i < 10; i++) begin
         idle(1);
         chk_busy("div busy", 1);
      end
      idle(1);
      chk_busy("div done", 0);
      chk("div LO", l_lo, 32'hFFFFFFFD);
      chk("div HI", l_hi, 32'hFFFFFFFF);

      // DIVU by zero leaves HI/LO alone
      tick(0, 1, 4'd4, 32'd7, 32'd0);
      idle(10);
      chk_busy("divz busy", 1);
      idle(1);
      chk_busy("divz done", 0);
      chk("divz HI", l_hi, 32'hFFFFFFFF);
      chk("divz LO", l_lo, 32'hFFFFFFFD);

      // Signed overflow divide
      tick(0, 1, 4'd3, 32'h80000000, 32'hFFFFFFFF);
      idle(11);
      chk("ovf LO", l_lo, 32'h80000000);
      chk("ovf HI", l_hi, 32'h0);

      // NOP with start, then MFLO
      tick(0, 1, 4'd0, 32'h55, 32'h66);
      tick(0, 1, 4'd8, 32'h0, 32'h0);
      chk_busy("nop busy", 0);
      chk("mflo out", l_out, 32'h80000000);

      // MTHI / MFHI, MTLO / MFLO
      tick(0, 1, 4'd5, 32'h1234, 32'h0);
      chk_busy("mthi busy", 0);
      tick(0, 1, 4'd7, 32'h0, 32'h0);
      chk("mfhi out", l_out, 32'h1234);
      chk("mthi HI", l_hi, 32'h1234);
      chk_busy("mfhi busy", 0);
      tick(0, 1, 4'd6, 32'h5678, 32'h0);
      tick(0, 1, 4'd8, 32'h0, 32'h0);
      chk("mflo out2", l_out, 32'h5678);

      // Ops while busy are ignored
      tick(0, 1, 4'd1, 32'd5, 32'd7);
      idle(1);
      tick(0, 1, 4'd6, 32'hAAAA, 32'h0);
      chk_busy("ign busy", 1);
      tick(0, 1, 4'd3, 32'd100, 32'd3);
      idle(2);
      chk_busy("ign T+5", 1);
      idle(1);
      chk_busy("ign T+6", 0);
      chk("ign LO", l_lo, 32'd35);
      chk("ign HI", l_hi, 32'd0);
      idle(1);
      chk_busy("ign no div", 0);

      // Reset mid-divide
      tick(0, 1, 4'd5, 32'hBEEF, 32'h0);
      tick(0, 1, 4'd3, 32'd100, 32'd7);
      idle(3);
      tick(1, 0, 4'd0, 0, 0);
      chk_busy("rst pre busy", 1);
      chk("rst pre HI", l_hi, 32'hBEEF);
      idle(1);
      chk_busy("rst busy", 0);
      chk("rst HI", l_hi, 32'h0);
      chk("rst LO", l_lo, 32'h0);
      idle(8);
      chk_busy("rst late busy", 0);
      chk("rst late HI", l_hi, 32'h0);
      chk("rst late LO", l_lo, 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
